// File: rtl/phase_mean_pkg.sv
// Shared types and sizing for the six-channel circular phase mean.
// Phase codes wrap modulo 2^DATA_W; accumulators are sized to never overflow.
package phase_mean_pkg;
  localparam int DATA_W = 16;
  localparam int KMAX   = 10;
  localparam int ACC_W  = DATA_W + KMAX + 1;
  localparam int N_CH   = 6;
  localparam int KW     = 4;
  localparam int CW     = KMAX + 1;

  typedef logic signed [DATA_W-1:0] phase_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic [KW-1:0]            kidx_t;
  typedef logic [CW-1:0]            cnt_t;

  function automatic kidx_t clamp_k(input logic [9:0] k);
    if (k > 10'(KMAX)) return kidx_t'(KMAX);
    return kidx_t'(k);
  endfunction
endpackage

// File: rtl/phase_mean_ch.sv
// One channel: reference, wrap-aware difference accumulator,
// staged window sum and the held output register.
import phase_mean_pkg::*;

module phase_mean_ch (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,
  input  logic   first_i,
  input  logic   close_i,
  input  logic   upd_i,
  input  kidx_t  k_i,
  input  phase_t smp_i,
  output phase_t out_o
);
  phase_t ref_q, fref_q, out_q;
  acc_t   acc_q, fin_q;
  phase_t ref_cur, d, out_d;
  acc_t   acc_sum, mean;

  always_comb begin
    ref_cur = first_i ? smp_i : ref_q;
    // 16-bit truncation makes the difference the short way round the circle
    d       = phase_t'(smp_i - ref_cur);
    acc_sum = (first_i ? acc_t'(0) : acc_q) + acc_t'(d);
    mean    = fin_q >>> k_i;
    out_d   = fref_q + phase_t'(mean);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q  <= '0;
      acc_q  <= '0;
      fin_q  <= '0;
      fref_q <= '0;
      out_q  <= '0;
    end else begin
      if (en_i) begin
        ref_q <= ref_cur;
        acc_q <= acc_sum;
      end
      if (close_i) begin
        fin_q  <= acc_sum;
        fref_q <= ref_cur;
      end
      if (upd_i) out_q <= out_d;
    end
  end

  assign out_o = out_q;
endmodule

// File: rtl/phase_mean.sv
// Six-channel circular block mean over 2^K enabled samples.
// Shared window counter and K latch; per-channel datapaths below.
import phase_mean_pkg::*;

module phase_mean (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] K,
  input  phase_t     in_sampl_1,
  input  phase_t     in_sampl_2,
  input  phase_t     in_sampl_3,
  input  phase_t     in_sampl_4,
  input  phase_t     in_sampl_5,
  input  phase_t     in_sampl_6,
  output phase_t     phaseout_1,
  output phase_t     phaseout_2,
  output phase_t     phaseout_3,
  output phase_t     phaseout_4,
  output phase_t     phaseout_5,
  output phase_t     phaseout_6
);
  cnt_t  cnt_q, cnt_d, last;
  kidx_t k_lat_q, k_fin_q, k_cur;
  logic  upd_q, first, close;
  phase_t in_a  [N_CH];
  phase_t out_a [N_CH];

  assign in_a[0] = in_sampl_1;
  assign in_a[1] = in_sampl_2;
  assign in_a[2] = in_sampl_3;
  assign in_a[3] = in_sampl_4;
  assign in_a[4] = in_sampl_5;
  assign in_a[5] = in_sampl_6;

  always_comb begin
    k_cur = (cnt_q == '0) ? clamp_k(K) : k_lat_q;
    last  = (cnt_t'(1) << k_cur) - cnt_t'(1);
    first = enable && (cnt_q == '0);
    close = enable && (cnt_q == last);
    cnt_d = cnt_q;
    if (enable) cnt_d = close ? '0 : cnt_q + cnt_t'(1);
  end

  // k_fin_q keeps the closing window's K when a new window relatches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      k_lat_q <= '0;
      k_fin_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      upd_q <= close;
      if (first) k_lat_q <= k_cur;
      if (close) k_fin_q <= k_cur;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    phase_mean_ch u_ch (
      .clk_i   (clock),
      .rst_ni  (reset),
      .en_i    (enable),
      .first_i (first),
      .close_i (close),
      .upd_i   (upd_q),
      .k_i     (k_fin_q),
      .smp_i   (in_a[c]),
      .out_o   (out_a[c])
    );
  end

  assign phaseout_1 = out_a[0];
  assign phaseout_2 = out_a[1];
  assign phaseout_3 = out_a[2];
  assign phaseout_4 = out_a[3];
  assign phaseout_5 = out_a[4];
  assign phaseout_6 = out_a[5];
endmodule

// File: tb/tb_phase_mean.sv
// Bench for phase_mean: window-list model checked every cycle,
// plus directed literal expectations.
module tb_phase_mean;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [9:0] K = '0;
  logic signed [15:0] in_s [6];
  logic signed [15:0] po [6];
  logic signed [15:0] exp_o [6];
  logic signed [15:0] pend_v [6];
  logic pend = 1'b0;
  int win [6][$];
  int wk = 0;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  phase_mean dut (
    .clock(clock), .reset(reset), .enable(enable), .K(K),
    .in_sampl_1(in_s[0]), .in_sampl_2(in_s[1]),
    .in_sampl_3(in_s[2]), .in_sampl_4(in_s[3]),
    .in_sampl_5(in_s[4]), .in_sampl_6(in_s[5]),
    .phaseout_1(po[0]), .phaseout_2(po[1]),
    .phaseout_3(po[2]), .phaseout_4(po[3]),
    .phaseout_5(po[4]), .phaseout_6(po[5])
  );

  // Model: collect each window's samples, then compute circular mean
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 6; c++) begin
        exp_o[c] = 0;
        win[c].delete();
      end
      pend = 1'b0;
    end else begin
      if (pend) begin
        for (int c = 0; c < 6; c++) exp_o[c] = pend_v[c];
        pend = 1'b0;
      end
      if (enable) begin
        if (win[0].size() == 0) wk = (K > 10) ? 10 : int'(K);
        for (int c = 0; c < 6; c++) win[c].push_back(int'(in_s[c]));
        if (win[0].size() == (1 << wk)) begin
          for (int c = 0; c < 6; c++) begin
            int r, s, n, q;
            logic signed [15:0] dd;
            r = win[c][0];
            s = 0;
            n = win[c].size();
            foreach (win[c][i]) begin
              dd = 16'(win[c][i] - r);
              s += int'(dd);
            end
            q = s / n;
            if (s < 0 && (s % n) != 0) q = q - 1;
            pend_v[c] = 16'(r + q);
            win[c].delete();
          end
          pend = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      for (int c = 0; c < 6; c++) begin
        checks++;
        if (po[c] !== exp_o[c]) begin
          errors++;
          $display("FAIL model ch%0d t=%0t got %0d want %0d",
                   c + 1, $time, po[c], exp_o[c]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic signed [15:0] a,
                     input logic signed [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic samp(input int k, input int a, input int b,
                      input int c, input int d);
    @(posedge clock);
    #2;
    enable = 1'b1;
    K = 10'(k);
    in_s[0] = 16'(a);
    in_s[1] = 16'(b);
    in_s[2] = 16'(c);
    in_s[3] = 16'(d);
    in_s[4] = 16'(a + 7);
    in_s[5] = 16'(-a);
  endtask

  task automatic idle();
    @(posedge clock);
    #2;
    enable = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 6; c++) in_s[c] = 0;
    #13;
    for (int c = 0; c < 6; c++) chk("reset_init", po[c], 16'sd0);
    reset = 1'b1;
    idle();

    // K=3 multi-channel window
    samp(3, 1000, 17000, -5985, 5759);
    samp(3, 2000, 17500, -5985, 15564);
    for (int i = 0; i < 6; i++)
      samp(3, (i % 2) ? 2000 : 1000, 17504, -5985, 5759);
    idle();
    idle();
    chk("k3_ch1", po[0], 16'sd1500);
    chk("k3_ch2", po[1], 16'sd17440);
    chk("k3_ch3", po[2], -16'sd5985);
    chk("k3_ch4", po[3], 16'sd6984);

    // Next window; output must hold until close
    for (int i = 0; i < 8; i++) begin
      samp(3, (i % 2) ? 15000 : 10000, 0, 0, 0);
      if (i == 6) chk("hold_mid", po[0], 16'sd1500);
    end
    idle();
    chk("hold_close", po[0], 16'sd1500);
    idle();
    chk("k3_w2_ch1", po[0], 16'sd12500);

    // Asynchronous reset mid-window
    samp(3, 4000, 1, 2, 3);
    samp(3, 4100, 1, 2, 3);
    idle();
    samp(3, 4200, 1, 2, 3);
    #1;
    reset = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) chk("reset_async", po[c], 16'sd0);
    idle();
    idle();
    reset = 1'b1;
    samp(1, 500, 0, 0, 0);
    samp(1, 700, 0, 0, 0);
    idle();
    idle();
    chk("fresh_ref", po[0], 16'sd600);

    // Wrap across +/-pi
    samp(1, 32000, 0, 0, 0);
    samp(1, -32000, 0, 0, 0);
    idle();
    idle();
    chk("wrap", po[0], -16'sd32768);

    // K=0 pass-through, back-to-back
    samp(0, 100, 0, 0, 0);
    samp(0, 200, 0, 0, 0);
    samp(0, 300, 0, 0, 0);
    chk("k0_a", po[0], 16'sd100);
    idle();
    chk("k0_b", po[0], 16'sd200);
    idle();
    chk("k0_c", po[0], 16'sd300);

    // K change mid-window applies to the next window
    for (int i = 0; i < 8; i++) begin
      samp((i < 3) ? 3 : 2, (i < 4) ? 0 : 80, 0, 0, 0);
      if (i == 5) chk("kchg_noclose", po[0], 16'sd300);
    end
    samp(2, 100, 0, 0, 0);
    chk("kchg_w1", po[0], 16'sd300);
    samp(2, 100, 0, 0, 0);
    chk("kchg_w1b", po[0], 16'sd40);
    samp(2, 100, 0, 0, 0);
    samp(2, 200, 0, 0, 0);
    idle();
    idle();
    chk("kchg_w2", po[0], 16'sd125);

    // K above KMAX clamps to a 1024-sample window
    for (int i = 0; i < 1024; i++)
      samp(15, (i == 1023) ? 1024 : 0, 0, 0, 0);
    idle();
    idle();
    chk("clamp", po[0], 16'sd1);

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
